// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared WS2812B constants, sequencer state encoding and GRB pixel type.
package ws2812b_pkg;
  localparam int BIT_CYCLES = 15;
  localparam int PIXEL_BITS = 24;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PRIME = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;
  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    FETCH = S_FETCH,
    PRIME = S_PRIME,
    SEND  = S_SEND,
    DRAIN = S_DRAIN,
    LATCH = S_LATCH
  } state_e;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/led_frame_sequencer_if.sv
// led_frame_sequencer_if: pixel memory, encoder handshake and frame control signals.
interface led_frame_sequencer_if #(parameter int NUM_LEDS = 64);
  import ws2812b_pkg::*;
  localparam int ADDR_W = addr_w(NUM_LEDS);
  logic start;
  logic shift;
  logic serial_out;
  logic transmit;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] pixel_addr;
  grb_t pixel_data;
  modport master (input start, shift, pixel_data, output pixel_addr, serial_out, transmit, busy, done);
  modport slave (output start, shift, pixel_data, input pixel_addr, serial_out, transmit, busy, done);
endinterface

// File: rtl/pixel_shift_reg.sv
// pixel_shift_reg: 24-bit MSB-first shift register with a one-deep prefetch slot swapped in after bit 0.
module pixel_shift_reg
  import ws2812b_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [PIXEL_BITS-1:0] din,
  output logic                  dout_msb
);
  logic [PIXEL_BITS-1:0] sr_q, pf_q;
  logic [4:0] cnt_q;
  logic vld_q;
  // the first load after reset fills the shifter, later loads fill the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
      pf_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      if (load && !vld_q) begin
        sr_q <= din;
        vld_q <= 1'b1;
      end else if (load) begin
        pf_q <= din;
      end
      if (shift) begin
        sr_q <= cnt_q == 5'(PIXEL_BITS - 1) ? pf_q : sr_q << 1;
        cnt_q <= cnt_q == 5'(PIXEL_BITS - 1) ? 5'd0 : cnt_q + 5'd1;
      end
    end
  end
  assign dout_msb = sr_q[PIXEL_BITS-1];
endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: streams NUM_LEDS GRB pixels to the WS2812B encoder, then holds the latch gap (LED_FRAME_AUTO_REFRESH_EN repeats frames).
module led_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS     = 64,
  parameter int LATCH_CYCLES = 1200
) (
  input logic clk,
  input logic reset,
  led_frame_sequencer_if.master bus
);
  localparam int ADDR_W = addr_w(NUM_LEDS);
  localparam int CNT_W = $clog2(LATCH_CYCLES + BIT_CYCLES);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pix_q, pix_d;
  logic [4:0] bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic trans_q, trans_d, busy_q, busy_d, done_q, done_d;
  logic iss_q, cap_q, issue, more, msb;
  assign more = int'(addr_q) < NUM_LEDS - 1;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    pix_d = pix_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    trans_d = trans_q;
    busy_d = busy_q;
    done_d = 1'b0;
    issue = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = bus.start ? FETCH : IDLE;
        busy_d = bus.start;
      end
      FETCH: begin
        state_d = PRIME;
        addr_d = ADDR_W'(NUM_LEDS > 1 ? 1 : 0);
        issue = 1'b1;
      end
      PRIME: begin
        state_d = SEND;
        trans_d = 1'b1;
      end
      SEND: begin
        if (bus.shift) begin
          bit_d = bit_q == 5'(PIXEL_BITS - 1) ? 5'd0 : bit_q + 5'd1;
          if (bit_q == 5'(PIXEL_BITS - 1) && pix_q == ADDR_W'(NUM_LEDS - 1)) begin
            state_d = DRAIN;
            cnt_d = '0;
          end else if (bit_q == 5'(PIXEL_BITS - 1)) begin
            pix_d = pix_q + ADDR_W'(1);
            addr_d = more ? addr_q + ADDR_W'(1) : addr_q;
            issue = more;
          end
        end
      end
      DRAIN: begin
        // keep transmit up until the encoder has finished the final bit period
        cnt_d = cnt_q == CNT_W'(BIT_CYCLES - 3) ? '0 : cnt_q + CNT_W'(1);
        state_d = cnt_q == CNT_W'(BIT_CYCLES - 3) ? LATCH : DRAIN;
        trans_d = cnt_q != CNT_W'(BIT_CYCLES - 3);
      end
      LATCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          done_d = 1'b1;
          cnt_d = '0;
          addr_d = '0;
          pix_d = '0;
          bit_d = '0;
`ifdef LED_FRAME_AUTO_REFRESH_EN
          state_d = FETCH;
`else
          state_d = IDLE;
          busy_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      pix_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      trans_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      iss_q <= 1'b0;
      cap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pix_q <= pix_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      trans_q <= trans_d;
      busy_q <= busy_d;
      done_q <= done_d;
      iss_q <= issue;
      cap_q <= iss_q;
    end
  end
  // memory data trails the address by a cycle, so the slot captures two cycles after an issue
  pixel_shift_reg u_shift (
    .clk(clk),
    .reset(reset || state_q == FETCH),
    .load(state_q == PRIME || cap_q),
    .shift(state_q == SEND && bus.shift),
    .din(bus.pixel_data),
    .dout_msb(msb)
  );
  assign bus.pixel_addr = addr_q;
  assign bus.serial_out = trans_q & msb;
  assign bus.transmit = trans_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
